// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Used by the write-back scheduler and the register file itself.
//   XLEN       : data width of one register
//   REG_ADDR_W : register address width
//   NUM_REGS   : number of architectural registers (x0 hardwired to zero)
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Which write-back source owns the write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester write-back arbiter: ALU has fixed priority over LSU.
// A starvation counter forces one LSU grant after STARVE_LIMIT
// consecutive cycles in which the LSU requested and was refused.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   alu_valid_i    : ALU write-back request
//   lsu_valid_i    : LSU write-back request
//   alu_gnt_o      : ALU granted (combinational)
//   lsu_gnt_o      : LSU granted (combinational)
//   src_o          : granted source, WB_NONE when idle
module wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    alu_valid_i,
    input  logic    lsu_valid_i,
    output logic    alu_gnt_o,
    output logic    lsu_gnt_o,
    output wb_src_e src_o
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            force_lsu;

    // Forcing only matters when the LSU is still asking; otherwise the ALU
    // keeps its slot.
    assign force_lsu = (starve_q == SC_W'(STARVE_LIMIT)) & lsu_valid_i;

    always_comb begin
        alu_gnt_o = alu_valid_i & ~force_lsu;
        lsu_gnt_o = lsu_valid_i & (force_lsu | ~alu_valid_i);
        src_o     = WB_NONE;
        if (alu_gnt_o) begin
            src_o = WB_ALU;
        end else if (lsu_gnt_o) begin
            src_o = WB_LSU;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!lsu_valid_i || lsu_gnt_o) begin
            starve_d = '0;
        end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Issue scoreboard and write-back scheduler for the 32x32 register file.
// Stalls issue on RAW/WAW hazards or when MAX_INFLIGHT writes are pending,
// and merges ALU/LSU write-backs onto the single registered write port.
// Ports:
//   issue_*_i / issue_ready_o : decode/issue handshake
//   alu_wb_*  / lsu_wb_*      : write-back request/grant per source
//   wrr_o, wrdata_o, is_regwrite_o : register file write port (1-cycle latency)
//   busy_o : per-register pending-write bits (bit 0 always 0)
//   err_o  : sticky, write-back committed to a non-busy register
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rs1_i,
    input  logic [REG_ADDR_W-1:0] issue_rs2_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  issue_rd_en_i,
    output logic                  issue_ready_o,
    input  logic                  alu_wb_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_wb_rd_i,
    input  logic [XLEN-1:0]       alu_wb_data_i,
    output logic                  alu_wb_ready_o,
    input  logic                  lsu_wb_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_wb_rd_i,
    input  logic [XLEN-1:0]       lsu_wb_data_i,
    output logic                  lsu_wb_ready_o,
    output logic [REG_ADDR_W-1:0] wrr_o,
    output logic [XLEN-1:0]       wrdata_o,
    output logic                  is_regwrite_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic                  err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    reg_addr_t           wrr_q, wrr_d;
    xlen_t               wrdata_q, wrdata_d;
    logic                wen_q, wen_d;
    logic                err_q, err_d;

    logic      hz, issue_acc, commit_hit;
    wb_src_e   wb_src;
    reg_addr_t wb_rd;
    xlen_t     wb_data;

    wb_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid_i(alu_wb_valid_i),
        .lsu_valid_i(lsu_wb_valid_i),
        .alu_gnt_o  (alu_wb_ready_o),
        .lsu_gnt_o  (lsu_wb_ready_o),
        .src_o      (wb_src)
    );

    // Hazard check reads registered busy only: a register committing this
    // cycle still stalls its consumer (no same-cycle bypass).
    assign hz = ((issue_rs1_i != '0) & busy_q[issue_rs1_i])
              | ((issue_rs2_i != '0) & busy_q[issue_rs2_i])
              | (issue_rd_en_i & (issue_rd_i != '0) & busy_q[issue_rd_i]);

    assign issue_ready_o = ~hz & (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign issue_acc     = issue_valid_i & issue_ready_o & issue_rd_en_i
                         & (issue_rd_i != '0);

    // Only a commit to a busy register retires an in-flight write.
    assign commit_hit = wen_q & busy_q[wrr_q];

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        case (wb_src)
            WB_ALU: begin
                wb_rd   = alu_wb_rd_i;
                wb_data = alu_wb_data_i;
            end
            WB_LSU: begin
                wb_rd   = lsu_wb_rd_i;
                wb_data = lsu_wb_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        wen_d    = (wb_src != WB_NONE) & (wb_rd != '0);
        wrr_d    = wrr_q;
        wrdata_d = wrdata_q;
        if (wen_d) begin
            wrr_d    = wb_rd;
            wrdata_d = wb_data;
        end

        // Set and clear never hit the same register: WAW stalls while busy.
        busy_d = busy_q;
        if (commit_hit) busy_d[wrr_q]      = 1'b0;
        if (issue_acc)  busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        inflight_d = inflight_q;
        case ({issue_acc, commit_hit})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: ;
        endcase

        err_d = err_q | (wen_q & ~busy_q[wrr_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            inflight_q <= '0;
            wrr_q      <= '0;
            wrdata_q   <= '0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            wrr_q      <= wrr_d;
            wrdata_q   <= wrdata_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
        end
    end

    assign wrr_o         = wrr_q;
    assign wrdata_o      = wrdata_q;
    assign is_regwrite_o = wen_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched. Expected register-file writes are
// queued by the stimulus; a monitor pops and compares on every write.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rs1_i = '0, issue_rs2_i = '0, issue_rd_i = '0;
    logic        issue_rd_en_i = 1'b0;
    logic        issue_ready_o;
    logic        alu_wb_valid_i = 1'b0;
    logic [4:0]  alu_wb_rd_i = '0;
    logic [31:0] alu_wb_data_i = '0;
    logic        alu_wb_ready_o;
    logic        lsu_wb_valid_i = 1'b0;
    logic [4:0]  lsu_wb_rd_i = '0;
    logic [31:0] lsu_wb_data_i = '0;
    logic        lsu_wb_ready_o;
    logic [4:0]  wrr_o;
    logic [31:0] wrdata_o;
    logic        is_regwrite_o;
    logic [31:0] busy_o;
    logic        err_o;

    regfile_wb_sched #(
        .MAX_INFLIGHT(4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
        .issue_rd_en_i(issue_rd_en_i), .issue_ready_o(issue_ready_o),
        .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_rd_i(alu_wb_rd_i),
        .alu_wb_data_i(alu_wb_data_i), .alu_wb_ready_o(alu_wb_ready_o),
        .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_rd_i(lsu_wb_rd_i),
        .lsu_wb_data_i(lsu_wb_data_i), .lsu_wb_ready_o(lsu_wb_ready_o),
        .wrr_o(wrr_o), .wrdata_o(wrdata_o), .is_regwrite_o(is_regwrite_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // expected write.
    always @(negedge clk) begin
        if (rst_n && is_regwrite_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rd", {27'd0, wrr_o}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, wrr_o}, {27'd0, e.rd});
                chk("wb_data", wrdata_o, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid_i = 1'b0; issue_rd_en_i = 1'b0;
        issue_rs1_i = '0; issue_rs2_i = '0; issue_rd_i = '0;
        alu_wb_valid_i = 1'b0; alu_wb_rd_i = '0; alu_wb_data_i = '0;
        lsu_wb_valid_i = 1'b0; lsu_wb_rd_i = '0; lsu_wb_data_i = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rd_en);
        issue_valid_i = 1'b1; issue_rs1_i = rs1; issue_rs2_i = rs2;
        issue_rd_i = rd; issue_rd_en_i = rd_en;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_wb_valid_i = 1'b1; alu_wb_rd_i = rd; alu_wb_data_i = d;
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
        lsu_wb_valid_i = 1'b1; lsu_wb_rd_i = rd; lsu_wb_data_i = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wr_t w;
        // ---- reset state ----
        #2;
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_wen", {31'd0, is_regwrite_o}, 32'd0);
        chk("rst_wrr", {27'd0, wrr_o}, 32'd0);
        chk("rst_wrdata", wrdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        mid(); rst_n = 1'b1;
        step();

        // ---- issue rd=5, then reset mid-flight with a write registered ----
        issue(5'd1, 5'd2, 5'd5, 1'b1);
        mid(); chk("issue5_ready", {31'd0, issue_ready_o}, 32'd1);
        step(); idle();
        chk("issue5_busy", busy_o, 32'h0000_0020);
        alu(5'd5, 32'h1111_1111);
        step(); idle();
        rst_n = 1'b0;   // write on the port is dropped, never seen by monitor
        #1;
        chk("midrst_busy", busy_o, 32'h0);
        chk("midrst_wen", {31'd0, is_regwrite_o}, 32'd0);
        mid(); rst_n = 1'b1;
        step();

        // ---- RAW stall and commit timing ----
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        step();
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        alu(5'd5, 32'hDEAD_BEEF);
        mid();
        chk("raw_ready", {31'd0, issue_ready_o}, 32'd0);
        chk("raw_alu_gnt", {31'd0, alu_wb_ready_o}, 32'd1);
        w.rd = 5'd5; w.data = 32'hDEAD_BEEF; exp_q.push_back(w);
        step();
        alu_wb_valid_i = 1'b0;
        mid();
        chk("raw_commit_wen", {31'd0, is_regwrite_o}, 32'd1);
        chk("raw_commit_wrr", {27'd0, wrr_o}, 32'd5);
        chk("raw_commit_data", wrdata_o, 32'hDEAD_BEEF);
        chk("raw_commit_ready", {31'd0, issue_ready_o}, 32'd0);
        step();
        mid();
        chk("raw_after_busy", busy_o, 32'h0);
        chk("raw_after_ready", {31'd0, issue_ready_o}, 32'd1);
        step(); idle();

        // ---- simultaneous ALU and LSU write-back ----
        issue(5'd0, 5'd0, 5'd3, 1'b1); step();
        issue(5'd0, 5'd0, 5'd4, 1'b1); step(); idle();
        alu(5'd3, 32'hAAAA_0003); lsu(5'd4, 32'hBBBB_0004);
        mid();
        chk("both_alu_gnt", {31'd0, alu_wb_ready_o}, 32'd1);
        chk("both_lsu_gnt", {31'd0, lsu_wb_ready_o}, 32'd0);
        w.rd = 5'd3; w.data = 32'hAAAA_0003; exp_q.push_back(w);
        step(); alu_wb_valid_i = 1'b0;
        mid();
        chk("both_lsu_next", {31'd0, lsu_wb_ready_o}, 32'd1);
        chk("both_wrr3", {27'd0, wrr_o}, 32'd3);
        w.rd = 5'd4; w.data = 32'hBBBB_0004; exp_q.push_back(w);
        step(); idle();
        mid();
        chk("both_wrr4", {27'd0, wrr_o}, 32'd4);
        step(); step();
        chk("both_busy_clear", busy_o, 32'h0);

        // ---- starvation ----
        for (int i = 10; i < 14; i++) begin
            issue(5'd0, 5'd0, 5'(i), 1'b1); step();
        end
        idle();
        lsu(5'd13, 32'h5500_000D);
        for (int i = 10; i < 13; i++) begin
            alu(5'(i), 32'hA100_0000 + 32'(i));
            mid();
            chk("starve_lsu_refused", {31'd0, lsu_wb_ready_o}, 32'd0);
            chk("starve_alu_gnt", {31'd0, alu_wb_ready_o}, 32'd1);
            w.rd = 5'(i); w.data = 32'hA100_0000 + 32'(i); exp_q.push_back(w);
            step();
        end
        alu(5'd14, 32'hBAD0_0014);
        mid();
        chk("starve_forced_lsu", {31'd0, lsu_wb_ready_o}, 32'd1);
        chk("starve_alu_refused", {31'd0, alu_wb_ready_o}, 32'd0);
        w.rd = 5'd13; w.data = 32'h5500_000D; exp_q.push_back(w);
        step();
        // counter cleared: ALU wins again (rd=0 write is dropped)
        alu(5'd0, 32'h0BAD_0000); lsu(5'd0, 32'h0BAD_0001);
        mid();
        chk("starve_reset_alu", {31'd0, alu_wb_ready_o}, 32'd1);
        chk("starve_reset_lsu", {31'd0, lsu_wb_ready_o}, 32'd0);
        step(); idle();
        mid();
        chk("rd0_no_write", {31'd0, is_regwrite_o}, 32'd0);
        chk("rd0_no_err", {31'd0, err_o}, 32'd0);
        step();
        chk("starve_busy_clear", busy_o, 32'h0);

        // ---- capacity ----
        for (int i = 1; i < 5; i++) begin
            issue(5'd0, 5'd0, 5'(i), 1'b1);
            mid(); chk("cap_issue_ready", {31'd0, issue_ready_o}, 32'd1);
            step();
        end
        issue(5'd0, 5'd0, 5'd6, 1'b1);
        alu(5'd2, 32'h0000_C002);
        mid(); chk("cap_full_stall", {31'd0, issue_ready_o}, 32'd0);
        w.rd = 5'd2; w.data = 32'h0000_C002; exp_q.push_back(w);
        step(); alu_wb_valid_i = 1'b0;
        mid(); chk("cap_commit_stall", {31'd0, issue_ready_o}, 32'd0);
        step();
        mid(); chk("cap_after_commit", {31'd0, issue_ready_o}, 32'd1);
        step();
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        mid();
        chk("cap_busy", busy_o, 32'h0000_005A);
        chk("cap_full_again", {31'd0, issue_ready_o}, 32'd0);
        step(); idle();
        for (int i = 1; i < 7; i++) begin
            if (i == 2 || i == 5) continue;
            alu(5'(i), 32'hC000_0000 + 32'(i));
            w.rd = 5'(i); w.data = 32'hC000_0000 + 32'(i); exp_q.push_back(w);
            step();
        end
        idle(); step(); step();
        chk("cap_drain_busy", busy_o, 32'h0);
        chk("cap_no_err", {31'd0, err_o}, 32'd0);

        // ---- write-back to non-busy register ----
        alu(5'd9, 32'h0000_9999);
        w.rd = 5'd9; w.data = 32'h0000_9999; exp_q.push_back(w);
        step(); idle();
        mid();
        chk("err_write_done", {31'd0, is_regwrite_o}, 32'd1);
        chk("err_pre", {31'd0, err_o}, 32'd0);
        step();
        chk("err_set", {31'd0, err_o}, 32'd1);
        chk("err_busy_unchanged", busy_o, 32'h0);
        step(); step();
        chk("err_sticky", {31'd0, err_o}, 32'd1);
        rst_n = 1'b0; #1;
        chk("err_cleared_by_reset", {31'd0, err_o}, 32'd0);
        mid(); rst_n = 1'b1;
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Issue scoreboard and write-back scheduler for the 32x32 integer register file.
- Tracks destination registers with writes in flight and stalls issue on RAW/WAW hazards.
- Arbitrates two write-back sources (ALU, LSU) onto the register file's single write port (wrr/wrdata/is_regwrite).
- Sits between the decode/issue stage and the register file.

Parameters:
- MAX_INFLIGHT, 4, maximum outstanding register writes (1..31).
- STARVE_LIMIT, 3, consecutive LSU-blocked cycles before the LSU is given one forced grant (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  decode presents an instruction.
- issue_rs1_i  in  5  source register 1.
- issue_rs2_i  in  5  source register 2.
- issue_rd_i  in  5  destination register.
- issue_rd_en_i  in  1  instruction writes rd.
- issue_ready_o  out  1  issue accepted this cycle when high with issue_valid_i.
- alu_wb_valid_i  in  1  ALU write-back request.
- alu_wb_rd_i  in  5  ALU destination.
- alu_wb_data_i  in  32  ALU result.
- alu_wb_ready_o  out  1  ALU request granted.
- lsu_wb_valid_i  in  1  LSU write-back request.
- lsu_wb_rd_i  in  5  LSU destination.
- lsu_wb_data_i  in  32  load data.
- lsu_wb_ready_o  out  1  LSU request granted.
- wrr_o  out  5  register file write address.
- wrdata_o  out  32  register file write data.
- is_regwrite_o  out  1  register file write enable.
- busy_o  out  32  scoreboard bits; bit 0 is always 0.
- err_o  out  1  sticky: write-back to a non-busy register.

Behaviour:
- Reset (async, rst_n low): busy=0, inflight=0, starve counter=0, is_regwrite_o=0, wrr_o=0, wrdata_o=0, err_o=0. Reset mid-operation discards all in-flight state. Any write already registered on the outputs is dropped.
- Hazard rule: hz = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (rd_en & rd!=0 & busy[rd]).
- issue_ready_o = !hz & (inflight < MAX_INFLIGHT). It is combinational from the inputs and registered state.
- Issue accept: on (issue_valid_i & issue_ready_o & rd_en & rd!=0), set busy[rd] and increment inflight. When rd=0 or !rd_en, the issue is accepted with no scoreboard change.
- Arbitration: single grant per cycle. The ALU has fixed priority.
  - The LSU is granted when the ALU is not valid.
  - Forced-LSU mode: when starve_cnt==STARVE_LIMIT, the LSU is granted and the ALU is refused.
  - ready outputs are combinational grants; a handshake completes on valid & ready.
- Starve counter: increments each cycle lsu_wb_valid_i is high and not granted. Clears on an LSU grant or when lsu_wb_valid_i is low. Saturates at STARVE_LIMIT.
- Write port: registered, 1-cycle latency. On a granted handshake with rd!=0, the next edge sets is_regwrite_o=1 and loads wrr_o/wrdata_o. With no grant, or rd=0, is_regwrite_o=0 on the next edge; wrr_o/wrdata_o hold.
- Commit: in the cycle is_regwrite_o=1, the same edge that writes the register file clears busy[wrr_o] and decrements inflight.
- No same-cycle bypass. A consumer of rd stalls through the commit cycle and may issue the cycle after.
- Simultaneous issue accept and commit: inflight is unchanged. The set and clear cannot target the same register, because the WAW check stalls while busy.
- Commit to a non-busy register: the write is still performed, busy and inflight are unchanged, and err_o is set until reset.
- Busy and inflight never exceed bounds. A decrement at inflight=0 does not occur, because it is covered by the error case.

Decomposition:
- Package regfile_pkg: XLEN=32, REG_ADDR_W=5, NUM_REGS=32; shared with the register file.
- Sub-module wb_arbiter: two-requester fixed-priority grant plus the starvation counter.
- Scoreboard and write-port register stay in the top module.

Test Plan:
- Reset, then issue rd=5 (rs1=1, rs2=2) -> issue_ready_o=1, busy_o[5]=1, inflight=1. Assert rst_n low mid-flight -> busy_o=0, is_regwrite_o=0 immediately.
- RAW stall: rd=5 busy, issue rs1=5 -> ready=0. ALU wb rd=5 data=0xDEADBEEF -> next cycle is_regwrite_o=1, wrr_o=5, wrdata_o=0xDEADBEEF, ready still 0. Following cycle busy_o[5]=0 and ready=1.
- Simultaneous ALU (rd=3) and LSU (rd=4) wb -> ALU granted, lsu_wb_ready_o=0. LSU granted the next cycle; writes to 3 then 4 on consecutive cycles.
- Starvation: ALU valid every cycle, LSU valid -> LSU refused 3 cycles, granted on the 4th with alu_wb_ready_o=0, then the counter resets.
- Capacity: issue rd=1..4 -> 5th issue (rd=6) stalls. Commit rd=2 -> rd=6 is accepted the cycle after the commit; inflight=4.
- Edge cases: ALU wb rd=0 -> granted, is_regwrite_o stays 0. Wb to non-busy rd=9 -> register written, err_o=1 sticky until reset.
